// File: rtl/dac_frame_loader.sv
// Serial 16-bit DAC control frame loader: synchronizes cs_n/sdi/bit_en, shifts a frame,
// and loads vref/vr/vm/vrc on a good frame. Optional even parity on bit 0 via DAC_FRAME_PARITY_EN.
module dac_frame_loader #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] VREF_RST    = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       sdi,
  input  logic       bit_en,
  output logic [3:0] vref,
  output logic [2:0] vr,
  output logic [2:0] vm,
  output logic [2:0] vrc,
  output logic       upd,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic [SYNC_STAGES-1:0] be_sync_q, be_sync_d;
  logic                   cs_s, sdi_s, be_s;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] sreg_q, sreg_d;
  logic [3:0]  vref_q, vref_d;
  logic [2:0]  vr_q, vr_d, vm_q, vm_d, vrc_q, vrc_d;
  logic        upd_q, upd_d;
  logic        err_q, err_d;
  logic        arm_q, arm_d;
  logic        frame_ok;
  logic        unused_rsvd;

  always_comb begin
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
    be_sync_d  = {be_sync_q[SYNC_STAGES-2:0], bit_en};
  end

  assign cs_s  = cs_sync_q[SYNC_STAGES-1];
  assign sdi_s = sdi_sync_q[SYNC_STAGES-1];
  assign be_s  = be_sync_q[SYNC_STAGES-1];

`ifdef DAC_FRAME_PARITY_EN
  assign frame_ok = ~^sreg_q;
`else
  assign frame_ok = 1'b1;
`endif
  assign unused_rsvd = ^sreg_q[2:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    vref_d  = vref_q;
    vr_d    = vr_q;
    vm_d    = vm_q;
    vrc_d   = vrc_q;
    upd_d   = 1'b0;
    err_d   = 1'b0;
    // a frame may only start once synced cs_n has been seen high since reset
    arm_d   = arm_q | cs_s;
    case (state_q)
      S_IDLE: begin
        if (!cs_s && arm_q) begin
          state_d = S_SHIFT;
          cnt_d   = 5'd0;
        end
      end
      S_SHIFT: begin
        if (cs_s) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (be_s) begin
          sreg_d = {sreg_q[14:0], sdi_s};
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd15) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = S_WAIT;
        if (frame_ok) begin
          vref_d = sreg_q[15:12];
          vr_d   = sreg_q[11:9];
          vm_d   = sreg_q[8:6];
          vrc_d  = sreg_q[5:3];
          upd_d  = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (cs_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q  <= '1;
      sdi_sync_q <= '0;
      be_sync_q  <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      sreg_q     <= 16'd0;
      vref_q     <= VREF_RST;
      vr_q       <= 3'd0;
      vm_q       <= 3'd0;
      vrc_q      <= 3'd0;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      cs_sync_q  <= cs_sync_d;
      sdi_sync_q <= sdi_sync_d;
      be_sync_q  <= be_sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sreg_q     <= sreg_d;
      vref_q     <= vref_d;
      vr_q       <= vr_d;
      vm_q       <= vm_d;
      vrc_q      <= vrc_d;
      upd_q      <= upd_d;
      err_q      <= err_d;
      arm_q      <= arm_d;
    end
  end

  assign vref      = vref_q;
  assign vr        = vr_q;
  assign vm        = vm_q;
  assign vrc       = vrc_q;
  assign upd       = upd_q;
  assign frame_err = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dac_frame_loader.sv
// Bench for dac_frame_loader: frame-level reference model checked every cycle, plus
// directed literal checks. Honors DAC_FRAME_PARITY_EN like the design.
module tb_dac_frame_loader;

  localparam int SYNC = 2;
  localparam logic [3:0] VREF_RST = 4'h0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_n = 1'b1;
  logic       sdi = 1'b0;
  logic       bit_en = 1'b0;
  logic [3:0] vref;
  logic [2:0] vr, vm, vrc;
  logic       upd, frame_err, busy;

  dac_frame_loader #(.SYNC_STAGES(SYNC), .VREF_RST(VREF_RST)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sdi(sdi), .bit_en(bit_en),
    .vref(vref), .vr(vr), .vm(vm), .vrc(vrc),
    .upd(upd), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int upd_seen = 0;
  int err_seen = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  typedef struct packed {logic cs; logic sd; logic be;} in_t;
  in_t  syncq[$];
  logic bits[$];
  bit   collecting, pending, waiting, seen_high;
  logic [3:0] exp_vref;
  logic [2:0] exp_vr, exp_vm, exp_vrc;
  logic exp_upd, exp_err;

  function automatic bit frame_good(input logic [15:0] w);
`ifdef DAC_FRAME_PARITY_EN
    return ($countones(w) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    syncq.delete();
    for (int i = 0; i < SYNC; i++) syncq.push_back('{cs: 1'b1, sd: 1'b0, be: 1'b0});
    bits.delete();
    collecting = 0; pending = 0; waiting = 0; seen_high = 0;
    exp_vref = VREF_RST; exp_vr = 0; exp_vm = 0; exp_vrc = 0;
    exp_upd = 0; exp_err = 0;
  endtask

  // inputs reach the frame logic SYNC edges after they are applied
  task automatic model_step();
    in_t s;
    logic [15:0] w;
    s = syncq.pop_front();
    syncq.push_back('{cs: cs_n, sd: sdi, be: bit_en});
    exp_upd = 0;
    exp_err = 0;
    if (pending) begin
      pending = 0;
      waiting = 1;
      w = '0;
      for (int i = 0; i < 16; i++) w = {w[14:0], bits[i]};
      if (frame_good(w)) begin
        exp_vref = w[15:12]; exp_vr = w[11:9]; exp_vm = w[8:6]; exp_vrc = w[5:3];
        exp_upd = 1;
      end else exp_err = 1;
    end else if (waiting) begin
      if (s.cs) waiting = 0;
    end else if (collecting) begin
      if (s.cs) begin
        collecting = 0;
        exp_err = 1;
      end else if (s.be) begin
        bits.push_back(s.sd);
        if (bits.size() == 16) begin
          collecting = 0;
          pending = 1;
        end
      end
    end else if (!s.cs && seen_high) begin
      collecting = 1;
      bits.delete();
    end
    if (s.cs) seen_high = 1;
  endtask

  always @(negedge clk) begin
    check("upd", {15'd0, upd}, {15'd0, exp_upd});
    check("frame_err", {15'd0, frame_err}, {15'd0, exp_err});
    check("busy", {15'd0, busy}, {15'd0, (collecting | pending | waiting)});
    check("words", {3'd0, vref, vr, vm, vrc}, {3'd0, exp_vref, exp_vr, exp_vm, exp_vrc});
    if (upd) upd_seen++;
    if (frame_err) err_seen++;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic c, input logic s, input logic b);
    cs_n = c; sdi = s; bit_en = b;
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1, 1'b0, 1'b0);
  endtask

  // nb bits of w, then extra ones; if nb<16 the frame is aborted by raising cs_n,
  // optionally together with a bit_en strobe
  task automatic send_frame(input logic [15:0] w, input int nb, input int extra,
                            input bit abort_with_bit, input int maxgap);
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(maxgap, 0)) tick(1'b0, 1'($urandom), 1'b0);
      tick(1'b0, w[15-i], 1'b1);
    end
    for (int i = 0; i < extra; i++) tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'(abort_with_bit));
    idle(6);
  endtask

  function automatic logic [15:0] make_frame(input logic [15:0] w);
    logic [15:0] r;
    r = w;
    r[0] = ^w[15:1];
    return r;
  endfunction

  task automatic check_words(input string name, input logic [15:0] w);
    check(name, {3'd0, vref, vr, vm, vrc}, {3'd0, w[15:12], w[11:9], w[8:6], w[5:3]});
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_vref", {12'd0, vref}, {12'd0, VREF_RST});
    check("rst_words", {7'd0, vr, vm, vrc}, 16'd0);
    check("rst_flags", {13'd0, upd, frame_err, busy}, 16'd0);
    cs_n = 1'b1; sdi = 1'b0; bit_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  logic [15:0] xf;
  int u0, e0;

  initial begin
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    check("reset_vref", {12'd0, vref}, {12'd0, VREF_RST});
    check("reset_words", {7'd0, vr, vm, vrc}, 16'd0);
    check("reset_flags", {13'd0, upd, frame_err, busy}, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);

    // basic frame, literal expected words
    u0 = upd_seen; e0 = err_seen;
    send_frame(16'hAAF0, 16, 0, 0, 0);
    check("aaf0_upd", 16'(upd_seen - u0), 16'd1);
    check("aaf0_err", 16'(err_seen - e0), 16'd0);
    check("aaf0_vref", {12'd0, vref}, 16'hA);
    check("aaf0_vr", {13'd0, vr}, 16'b101);
    check("aaf0_vm", {13'd0, vm}, 16'b011);
    check("aaf0_vrc", {13'd0, vrc}, 16'b110);

    // odd-parity frame
    u0 = upd_seen; e0 = err_seen;
    send_frame(16'hAAF1, 16, 0, 0, 0);
`ifdef DAC_FRAME_PARITY_EN
    check("aaf1_upd", 16'(upd_seen - u0), 16'd0);
    check("aaf1_err", 16'(err_seen - e0), 16'd1);
`else
    check("aaf1_upd", 16'(upd_seen - u0), 16'd1);
    check("aaf1_err", 16'(err_seen - e0), 16'd0);
`endif
    check("aaf1_words", {3'd0, vref, vr, vm, vrc}, {3'd0, 4'hA, 3'b101, 3'b011, 3'b110});

    // abort after 9 bits, then a good frame
    xf = make_frame(16'h1234);
    send_frame(xf, 16, 0, 0, 0);
    u0 = upd_seen; e0 = err_seen;
    send_frame(16'hAAF0, 9, 0, 0, 0);
    check("abort9_err", 16'(err_seen - e0), 16'd1);
    check("abort9_upd", 16'(upd_seen - u0), 16'd0);
    check("abort9_busy", {15'd0, busy}, 16'd0);
    check_words("abort9_hold", xf);
    send_frame(16'hAAF0, 16, 0, 0, 0);
    check_words("after_abort", 16'hAAF0);

    // 20 bit strobes: extras in WAIT are discarded
    send_frame(xf, 16, 0, 0, 0);
    u0 = upd_seen; e0 = err_seen;
    send_frame(16'hAAF0, 16, 4, 0, 0);
    check("extra_upd", 16'(upd_seen - u0), 16'd1);
    check("extra_err", 16'(err_seen - e0), 16'd0);
    check_words("extra_words", 16'hAAF0);

    // reset in the middle of a frame
    u0 = upd_seen; e0 = err_seen;
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b0, xf[15-i], 1'b1);
    pulse_reset();
    idle(8);
    check("rst_mid_upd", 16'(upd_seen - u0), 16'd0);
    check("rst_mid_err", 16'(err_seen - e0), 16'd0);

    // cs_n and bit_en rise together on the 10th bit
    u0 = upd_seen; e0 = err_seen;
    send_frame(16'hAAF0, 9, 0, 1, 0);
    check("abort10_err", 16'(err_seen - e0), 16'd1);
    check("abort10_upd", 16'(upd_seen - u0), 16'd0);
    check("abort10_words", {7'd0, vr, vm, vrc}, 16'd0);

    // randomized frames against the model
    for (int n = 0; n < 150; n++) begin
      int r;
      logic [15:0] w;
      r = $urandom_range(99, 0);
      w = 16'($urandom);
      if ($urandom_range(3, 0) != 0) w = make_frame(w);
      if (r < 60)
        send_frame(w, 16, $urandom_range(5, 0), 0, 2);
      else if (r < 90)
        send_frame(w, $urandom_range(15, 1), 0, 1'($urandom), 2);
      else begin
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < int'($urandom_range(15, 1)); i++) tick(1'b0, w[15-i], 1'b1);
        pulse_reset();
        idle(4);
      end
      idle($urandom_range(3, 0));
    end

    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
